// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads take strict priority; camera writes are
// queued in a small FIFO and drained on idle cycles. FB_ARB_STATS_EN adds stall/high-water outputs.
module fb_port_arbiter #(
    parameter int ADDR_W        = 17,
    parameter int DATA_W        = 16,
    parameter int WR_FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rd_req,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    input  logic                           wr_valid,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           wr_ready,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           mem_we,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic [$clog2(WR_FIFO_DEPTH):0] fifo_level
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]                    stall_cnt,
    output logic [$clog2(WR_FIFO_DEPTH):0] max_level
`endif
);

    localparam int PTR_W   = $clog2(WR_FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(WR_FIFO_DEPTH);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_RD,
        GNT_WR
    } gnt_t;

    gnt_t              gnt;
    logic [ADDR_W-1:0] fifo_addr [WR_FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WR_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [1:0]        rd_pipe;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LEVEL);
    // Held low while reset is asserted, so the camera sees ready only once reset is released.
    assign wr_ready   = !reset && !fifo_full;
    assign push       = wr_valid && wr_ready;
    assign pop        = (gnt == GNT_WR);
    assign rd_valid   = rd_pipe[1];
    assign rd_data    = mem_rdata;

    always_comb begin
        gnt = GNT_IDLE;
        if (rd_req)
            gnt = GNT_RD;
        else if (!fifo_empty)
            gnt = GNT_WR;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rd_pipe    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            rd_pipe <= {rd_pipe[0], (gnt == GNT_RD)};

            mem_we <= 1'b0;
            case (gnt)
                GNT_RD: mem_addr <= rd_addr;
                GNT_WR: begin
                    mem_addr  <= fifo_addr[rd_ptr];
                    mem_wdata <= fifo_data[rd_ptr];
                    mem_we    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            max_level <= '0;
        end else begin
            if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 1'b1;
            if (fifo_level > max_level)
                max_level <= fifo_level;
        end
    end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: vector table for read/write/ordering cases,
// plus hand sequences for write starvation, drain order and mid-operation reset.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [3:0]  fifo_level;
`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [3:0]  max_level;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fb_port_arbiter #(
        .ADDR_W(17),
        .DATA_W(16),
        .WR_FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .fifo_level(fifo_level)
`ifdef FB_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .max_level(max_level)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, 1-cycle read latency, read-before-write.
    logic [15:0] ram [0:131071];
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        rd_req;
        logic [16:0] rd_addr;
        logic        wr_valid;
        logic [16:0] wr_addr;
        logic [15:0] wr_data;
        logic        e_we;
        logic [16:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_rv;
        logic [15:0] e_rdata;
        logic [3:0]  e_level;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rq, input logic [16:0] ra, input logic wv,
                         input logic [16:0] wa, input logic [15:0] wd);
        rd_req   = rq;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [32:0] q [$];
    logic [32:0] exp_entry;
    int unsigned pushes;
    int unsigned drained;
    int unsigned stall_exp;
    logic        we_seen;

    initial begin
        ram[100] = 16'hABCD;
        ram[9]   = 16'hBEEF;
        ram[6]   = 16'h0000;

        //              rd  rd_addr   wv  wr_addr  wr_data   we  addr     wdata     rv  rdata     lvl
        vecs[0]  = '{1'b1, 17'd100, 1'b0, 17'd0, 16'h0,    1'b0, 17'd100, 16'h0000, 1'b0, 16'h0000, 4'd0};
        vecs[1]  = '{1'b0, 17'd0,   1'b0, 17'd0, 16'h0,    1'b0, 17'd100, 16'h0000, 1'b1, 16'hABCD, 4'd0};
        vecs[2]  = '{1'b0, 17'd0,   1'b1, 17'd5, 16'h1,    1'b0, 17'd100, 16'h0000, 1'b0, 16'h0000, 4'd1};
        vecs[3]  = '{1'b0, 17'd0,   1'b1, 17'd6, 16'h2,    1'b1, 17'd5,   16'h0001, 1'b0, 16'h0000, 4'd1};
        vecs[4]  = '{1'b0, 17'd0,   1'b1, 17'd7, 16'h3,    1'b1, 17'd6,   16'h0002, 1'b0, 16'h0000, 4'd1};
        vecs[5]  = '{1'b0, 17'd0,   1'b0, 17'd0, 16'h0,    1'b1, 17'd7,   16'h0003, 1'b0, 16'h0000, 4'd0};
        vecs[6]  = '{1'b0, 17'd0,   1'b0, 17'd0, 16'h0,    1'b0, 17'd7,   16'h0003, 1'b0, 16'h0000, 4'd0};
        vecs[7]  = '{1'b1, 17'd6,   1'b0, 17'd0, 16'h0,    1'b0, 17'd6,   16'h0003, 1'b0, 16'h0000, 4'd0};
        vecs[8]  = '{1'b1, 17'd100, 1'b1, 17'd9, 16'h55,   1'b0, 17'd100, 16'h0003, 1'b1, 16'h0002, 4'd1};
        vecs[9]  = '{1'b1, 17'd9,   1'b0, 17'd0, 16'h0,    1'b0, 17'd9,   16'h0003, 1'b1, 16'hABCD, 4'd1};
        vecs[10] = '{1'b0, 17'd0,   1'b0, 17'd0, 16'h0,    1'b1, 17'd9,   16'h0055, 1'b1, 16'hBEEF, 4'd0};
        vecs[11] = '{1'b0, 17'd0,   1'b0, 17'd0, 16'h0,    1'b0, 17'd9,   16'h0055, 1'b0, 16'h0000, 4'd0};
        vecs[12] = '{1'b1, 17'd9,   1'b0, 17'd0, 16'h0,    1'b0, 17'd9,   16'h0055, 1'b0, 16'h0000, 4'd0};
        vecs[13] = '{1'b0, 17'd0,   1'b0, 17'd0, 16'h0,    1'b0, 17'd9,   16'h0055, 1'b1, 16'h0055, 4'd0};

        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        step();
        step();
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {15'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
`ifdef FB_ARB_STATS_EN
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_max_level", {28'd0, max_level}, 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("wr_ready_after_rst", {31'd0, wr_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
            chk("idle_wr_ready", {31'd0, wr_ready}, 32'd1);
            chk("idle_level", {28'd0, fifo_level}, 32'd0);
            chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rd_req, vecs[i].rd_addr, vecs[i].wr_valid, vecs[i].wr_addr, vecs[i].wr_data);
            step();
            chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_mem_addr", i), {15'd0, mem_addr}, {15'd0, vecs[i].e_addr});
            chk($sformatf("v%0d_mem_wdata", i), {16'd0, mem_wdata}, {16'd0, vecs[i].e_wdata});
            chk($sformatf("v%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].e_rv});
            if (vecs[i].e_rv)
                chk($sformatf("v%0d_rd_data", i), {16'd0, rd_data}, {16'd0, vecs[i].e_rdata});
            chk($sformatf("v%0d_level", i), {28'd0, fifo_level}, {28'd0, vecs[i].e_level});
            chk($sformatf("v%0d_wr_ready", i), {31'd0, wr_ready}, 32'd1);
        end

        // Sustained reads starve the writer: FIFO fills, ready drops, RAM never written.
        pushes    = 0;
        stall_exp = 0;
        we_seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 17'd0, 1'b1, 17'(1000 + pushes), 16'(16'hC000 + pushes));
            if (wr_ready) begin
                q.push_back({1'b0, wr_addr, wr_data});
                pushes++;
            end else begin
                stall_exp++;
            end
            step();
            if (mem_we)
                we_seen = 1'b1;
        end
        chk("starve_pushes", pushes, 32'd8);
        chk("starve_no_we", {31'd0, we_seen}, 32'd0);
        chk("starve_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("starve_level", {28'd0, fifo_level}, 32'd8);

        drive(1'b0, '0, 1'b0, '0, '0);
        drained = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_we) begin
                if (q.size() == 0) begin
                    chk("drain_extra_write", {15'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_entry = q.pop_front();
                    chk("drain_addr", {15'd0, mem_addr}, {15'd0, exp_entry[32:16]});
                    chk("drain_data", {16'd0, mem_wdata}, {16'd0, exp_entry[15:0]});
                    drained++;
                end
            end
        end
        chk("drain_count", drained, 32'd8);
        chk("drain_level", {28'd0, fifo_level}, 32'd0);
        chk("drain_wr_ready", {31'd0, wr_ready}, 32'd1);
`ifdef FB_ARB_STATS_EN
        chk("stats_stall_cnt", {16'd0, stall_cnt}, stall_exp);
        chk("stats_max_level", {28'd0, max_level}, 32'd8);
`endif

        // Reset with five entries pending and a write in flight.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 17'd0, 1'b1, 17'(2000 + i), 16'(16'hD000 + i));
            step();
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        step();
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        chk("pre_rst_level", {28'd0, fifo_level}, 32'd5);
        reset = 1'b1;
        drive(1'b1, 17'd0, 1'b0, '0, '0);
        step();
        chk("mid_rst_level", {28'd0, fifo_level}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0);
        step();
        chk("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        we_seen = mem_we;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_we)
                we_seen = 1'b1;
        end
        chk("post_rst_no_write", {31'd0, we_seen}, 32'd0);
        chk("post_rst_level", {28'd0, fifo_level}, 32'd0);
`ifdef FB_ARB_STATS_EN
        chk("post_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("post_rst_max_level", {28'd0, max_level}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Arbitrates a single-port 320x240 RGB565 frame-buffer RAM between the display read path (pixel-address/read-data side feeding the VGA colour mux) and the camera write path. Display reads have strict priority. Camera writes go into a small internal FIFO and drain into the RAM only on cycles with no display read, i.e. during blanking or outside the 320x240 window. The block sits between the display pixel reader, the camera capture block and the frame-buffer RAM instance.

Parameters:
ADDR_W, 17, frame-buffer address width ($clog2(320*240))
DATA_W, 16, pixel width (RGB565)
WR_FIFO_DEPTH, 8, camera write FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rd_req  input  1  display requests a read this cycle
rd_addr  input  ADDR_W  display read address
rd_valid  output  1  rd_data valid (2 cycles after the accepted rd_req)
rd_data  output  DATA_W  read pixel, passthrough of mem_rdata
wr_valid  input  1  camera write request
wr_addr  input  ADDR_W  camera write address
wr_data  input  DATA_W  camera pixel
wr_ready  output  1  FIFO can accept; high when not full
mem_addr  output  ADDR_W  RAM address (registered)
mem_we  output  1  RAM write enable (registered)
mem_wdata  output  DATA_W  RAM write data (registered)
mem_rdata  input  DATA_W  RAM read data; synchronous RAM, 1-cycle latency
fifo_level  output  $clog2(WR_FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, rd_valid=0, FIFO empty, fifo_level=0, wr_ready=0 during reset and 1 in the first cycle after reset.
- Grant FSM, one decision per cycle in cycle t:
  - GNT_IDLE: no rd_req and FIFO empty.
  - GNT_RD: rd_req=1. Always taken, regardless of FIFO state.
  - GNT_WR: rd_req=0 and FIFO not empty. Pops the head entry.
- Cycle t+1, registered RAM outputs:
  - GNT_RD: mem_addr=rd_addr, mem_we=0.
  - GNT_WR: mem_addr/mem_wdata = popped entry, mem_we=1.
  - GNT_IDLE: mem_we=0; mem_addr and mem_wdata hold their previous values.
- Read latency: rd_req at t -> rd_valid=1 at t+2, with rd_data=mem_rdata. A 2-deep rd_valid shift register tracks GNT_RD. Back-to-back reads give rd_valid every cycle, 2 cycles delayed.
- FIFO: push when wr_valid && wr_ready.
  - wr_ready = !full; no pass-through when full, even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: fifo_level unchanged; order preserved.
  - An entry pushed at t is poppable at t+1 at the earliest.
- Write order: FIFO entries are written to the RAM strictly in push order. A read of an address with a pending FIFO entry returns the old RAM contents; no forwarding.
- Pointers wrap modulo WR_FIFO_DEPTH. fifo_level is the exact count 0..WR_FIFO_DEPTH.
- Sustained rd_req: writes starve, FIFO fills, and wr_ready drops. The camera side must stall; no data is lost.
- Reset mid-operation: FIFO flushed and pending writes discarded. An in-flight mem_we is deasserted the cycle after reset is sampled. rd_valid pipeline cleared.

Optional Feature:
FB_ARB_STATS_EN
- With it, two extra outputs are present:
  - stall_cnt [15:0]: increments every cycle wr_valid=1 && wr_ready=0; saturates at 16'hFFFF.
  - max_level: high-water mark of fifo_level.
- Both cleared only by reset.
- Without it, neither port nor logic exists; all other behaviour is identical.

Test Plan:
- Reset released, no requests -> mem_we=0, wr_ready=1, fifo_level=0, rd_valid=0 for 10 cycles.
- rd_req=1 with rd_addr=100 at t, RAM preloaded 16'hABCD -> mem_addr=100, mem_we=0 at t+1; rd_valid=1, rd_data=16'hABCD at t+2.
- 3 writes (addr 5,6,7, data 1,2,3) with rd_req=0 -> mem_we pulses 3 cycles starting 2 cycles after the first push, in order 5/1, 6/2, 7/3; fifo_level returns to 0.
- rd_req held high 20 cycles while wr_valid high -> exactly 8 pushes accepted, wr_ready=0, mem_we never 1. After rd_req drops, 8 writes drain in push order.
- Reset asserted with fifo_level=5 -> next cycle fifo_level=0 and mem_we=0; none of the 5 entries is ever written.
- FB_ARB_STATS_EN: stall for 10 cycles with FIFO full -> stall_cnt=10, max_level=8.
